// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS channel encoder.
// Holds the control tokens, the symbol width and the popcount used by both stages.
package tmds_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One TMDS channel: 8b/10b transition-minimise + DC-balance encode, or control token in blanking.
// Latency 2 clocks for data and control alike; no backpressure, one symbol every clock.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter logic [SYM_W-1:0] RESET_CODE = 10'b1101010100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de,
    input  logic [7:0]       data,
    input  logic             c0,
    input  logic             c1,
    output logic [SYM_W-1:0] tmds
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm;
    logic       acc;

    logic [8:0] qm_r;
    logic       de_r;
    logic [1:0] ctrl_r;

    logic signed [4:0] cnt;
    logic signed [4:0] cnt_nxt;
    logic [SYM_W-1:0]  tmds_nxt;

    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] n1_s;
    logic signed [4:0] n0_s;
    logic signed [4:0] two_qm8;
    logic signed [4:0] two_nqm8;

    // Stage 1: an XNOR chain equals the XOR prefix with every odd bit inverted.
    assign n1d      = popcnt8(data);
    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);

    always_comb begin
        qm    = '0;
        acc   = data[0];
        qm[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            acc   = acc ^ data[i];
            qm[i] = acc ^ (use_xnor && (i % 2 == 1));
        end
        qm[8] = ~use_xnor;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qm_r   <= '0;
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            qm_r   <= qm;
            de_r   <= de;
            ctrl_r <= {c1, c0};
        end
    end

    // Stage 2: popcounts widened to signed 5 bits so differences stay exact.
    assign n1       = popcnt8(qm_r[7:0]);
    assign n0       = 4'd8 - n1;
    assign n1_s     = signed'({1'b0, n1});
    assign n0_s     = signed'({1'b0, n0});
    assign two_qm8  = qm_r[8] ? 5'sd2 : 5'sd0;
    assign two_nqm8 = qm_r[8] ? 5'sd0 : 5'sd2;

    always_comb begin
        tmds_nxt = RESET_CODE;
        cnt_nxt  = cnt;
        if (!de_r) begin
            cnt_nxt = '0;
            unique case (ctrl_r)
                2'b00:   tmds_nxt = CTRL_TOKEN_00;
                2'b01:   tmds_nxt = CTRL_TOKEN_01;
                2'b10:   tmds_nxt = CTRL_TOKEN_10;
                default: tmds_nxt = CTRL_TOKEN_11;
            endcase
        end else if ((cnt == 5'sd0) || (n1 == n0)) begin
            tmds_nxt = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
            cnt_nxt  = qm_r[8] ? (cnt + (n1_s - n0_s)) : (cnt + (n0_s - n1_s));
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            tmds_nxt = {1'b1, qm_r[8], ~qm_r[7:0]};
            cnt_nxt  = cnt + two_qm8 + (n0_s - n1_s);
        end else begin
            tmds_nxt = {1'b0, qm_r[8], qm_r[7:0]};
            cnt_nxt  = cnt + (n1_s - n0_s) - two_nqm8;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmds <= RESET_CODE;
            cnt  <= '0;
        end else begin
            tmds <= tmds_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and randomised checks of tmds_encoder against an integer reference of the encoding rules.
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       de;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic [9:0] tmds;

    localparam logic [9:0] RST_CODE = 10'b1101010100;

    tmds_encoder #(.RESET_CODE(RST_CODE)) dut (
        .clk   (clk),
        .reset (reset),
        .de    (de),
        .data  (data),
        .c0    (c0),
        .c1    (c1),
        .tmds  (tmds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        int         cnt;
        bit         has_const;
        logic [9:0] cval;
        string      tag;
    } exp_t;

    exp_t expq[$];
    int   mcnt;
    int   n_pass   = 0;
    int   n_checks = 0;

    // Reference: rules applied with plain integer arithmetic.
    function automatic logic [9:0] ref_encode(input logic d_e, input logic [7:0] d,
                                              input logic [1:0] c, input int cnt_in,
                                              output int cnt_out);
        int         ones_d;
        int         ones_q;
        int         zeros_q;
        bit         xnor_mode;
        logic [8:0] q;
        logic [9:0] sym;
        if (!d_e) begin
            cnt_out = 0;
            case (c)
                2'b00:   return 10'b1101010100;
                2'b01:   return 10'b0010101011;
                2'b10:   return 10'b0101010100;
                default: return 10'b1010101011;
            endcase
        end
        ones_d = 0;
        for (int i = 0; i < 8; i++) ones_d += int'(d[i]);
        xnor_mode = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = xnor_mode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = xnor_mode ? 1'b0 : 1'b1;
        ones_q = 0;
        for (int i = 0; i < 8; i++) ones_q += int'(q[i]);
        zeros_q = 8 - ones_q;
        if (cnt_in == 0 || ones_q == zeros_q) begin
            sym     = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_out = cnt_in + (q[8] ? (ones_q - zeros_q) : (zeros_q - ones_q));
        end else if ((cnt_in > 0 && ones_q > zeros_q) || (cnt_in < 0 && zeros_q > ones_q)) begin
            sym     = {1'b1, q[8], ~q[7:0]};
            cnt_out = cnt_in + 2 * int'(q[8]) + (zeros_q - ones_q);
        end else begin
            sym     = {1'b0, q[8], q[7:0]};
            cnt_out = cnt_in + (ones_q - zeros_q) - 2 * int'(!q[8]);
        end
        return sym;
    endfunction

    task automatic check_sym(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp && obs >= -8 && obs <= 8) n_pass++;
        else $error("FAIL %s: observed cnt %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                        input bit hc, input logic [9:0] cv, input string tag);
        exp_t e;
        int   nc;
        @(negedge clk);
        if (expq.size() == 2) begin
            e = expq.pop_front();
            check_sym({e.tag, "_model"}, tmds, e.sym);
            check_cnt({e.tag, "_cnt"}, int'(dut.cnt), e.cnt);
            if (e.has_const) check_sym(e.tag, tmds, e.cval);
        end
        de   = d_e;
        data = d;
        {c1, c0} = c;
        e.sym       = ref_encode(d_e, d, c, mcnt, nc);
        mcnt        = nc;
        e.cnt       = nc;
        e.has_const = hc;
        e.cval      = cv;
        e.tag       = tag;
        expq.push_back(e);
    endtask

    task automatic apply_reset();
        exp_t e;
        #2 reset = 1'b1;
        #1 check_sym("async_reset", tmds, RST_CODE);
        de   = 1'b0;
        data = 8'h00;
        {c1, c0} = 2'b00;
        repeat (2) @(posedge clk);
        #1 check_sym("reset_hold", tmds, RST_CODE);
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        mcnt        = 0;
        e.sym       = RST_CODE;
        e.cnt       = 0;
        e.has_const = 1'b1;
        e.cval      = RST_CODE;
        e.tag       = "post_reset";
        expq.push_back(e);
        expq.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        de    = 1'b0;
        data  = 8'h00;
        c0    = 1'b0;
        c1    = 1'b0;
        #1 check_sym("reset_t0", tmds, RST_CODE);
        apply_reset();

        step(1'b0, 8'h00, 2'b01, 1'b1, 10'b0010101011, "ctrl01");
        step(1'b0, 8'h00, 2'b10, 1'b1, 10'b0101010100, "ctrl10");
        step(1'b0, 8'h00, 2'b11, 1'b1, 10'b1010101011, "ctrl11");
        step(1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100, "ctrl00");

        step(1'b1, 8'h00, 2'b00, 1'b1, 10'b0100000000, "zero_1");
        step(1'b1, 8'h00, 2'b00, 1'b1, 10'b1111111111, "zero_2");
        step(1'b1, 8'h00, 2'b00, 1'b1, 10'b0100000000, "zero_3");
        step(1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100, "blank_a");

        step(1'b1, 8'hFF, 2'b00, 1'b1, 10'b1000000000, "ones_1");
        step(1'b1, 8'hFF, 2'b00, 1'b1, 10'b0011111111, "ones_2");
        step(1'b0, 8'h00, 2'b01, 1'b1, 10'b0010101011, "blank_b");

        step(1'b1, 8'h0F, 2'b00, 1'b1, 10'b0100000101, "n4_xor");
        step(1'b0, 8'h00, 2'b00, 1'b0, 10'b0, "blank_c");
        step(1'b1, 8'hF0, 2'b00, 1'b1, 10'b1000000101, "n4_xnor");
        step(1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100, "blank_d");
        step(1'b1, 8'h00, 2'b00, 1'b1, 10'b0100000000, "after_blank");

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) apply_reset();
            step(($urandom_range(0, 4) != 0), 8'($urandom), 2'($urandom), 1'b0, 10'b0, "rand");
        end
        step(1'b0, 8'h00, 2'b00, 1'b0, 10'b0, "drain");
        step(1'b0, 8'h00, 2'b00, 1'b0, 10'b0, "drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
